apb_mac_slave13: RTL and testbench
==================================

APB_MAC_SLAVE13 -- requirements
Module: apb_mac_slave13

Interface
REQ-001 The block SHALL have parameter RST_WAIT13, default 3'd0, giving the reset value of WAIT[2:0].
REQ-002 The block SHALL have parameter CNT_W13, default 16, giving the width of EVT_CNT and ACC_CNT (legal range 8..32).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 pclk13  input  1  sole clock; all state updates on its rising edge.
REQ-005 preset13  input  1  synchronous active-high reset.
REQ-006 psel13  input  1  APB select from the bridge.
REQ-007 penable13  input  1  APB access-phase strobe.
REQ-008 pwrite13  input  1  1 = write, 0 = read.
REQ-009 paddr13  input  8  byte address; bits [1:0] ignored.
REQ-010 pwdata13  input  32  write data.
REQ-011 prdata13  output  32  read data; valid only while pready13=1 on a read, 0 otherwise.
REQ-012 pready13  output  1  transfer-complete strobe.
REQ-013 evt13  input  1  single-cycle event pulse from MAC datapath.

Function
REQ-014 The block SHALL implement FSM states IDLE and ACCESS: IDLE->ACCESS on psel13=1 & penable13=0 (setup), loading wait counter wcnt from WAIT; ACCESS->IDLE on pready13=1 or psel13=0.
REQ-015 pready13 SHALL be 1 exactly when state=ACCESS and wcnt=0, and wcnt SHALL decrement each ACCESS cycle while nonzero; transfer length = 2 + WAIT cycles.
REQ-016 Writes SHALL commit, and read data SHALL be sampled, only in the cycle pready13=1 with psel13=penable13=1; psel13 dropping in ACCESS aborts with no commit.
REQ-017 The register map SHALL be: 0x00 CTRL rw [0] EN; 0x04 WAIT rw [2:0]; 0x08 SCRATCH rw [31:0]; 0x0C EVT_CNT ro, any write clears; 0x10 ACC_CNT ro; 0x14 STATUS [0] OVF, write-1-to-clear; unused bits read 0.
REQ-018 Offsets 0x18-0xFC SHALL read 0, ignore writes, and still complete with normal wait states.
REQ-019 EVT_CNT SHALL increment on evt13=1 while EN=1, saturate at all-ones, and set OVF on an event arriving while saturated.
REQ-020 A clearing write to EVT_CNT coincident with evt13 SHALL yield EVT_CNT=0 (clear wins); an OVF set coincident with W1C SHALL leave OVF=1 (set wins).
REQ-021 ACC_CNT SHALL increment, wrapping modulo 2^CNT_W13, on every completed transfer (read or write, mapped or not).
REQ-022 A WAIT write SHALL take effect from the next setup phase, never the current transfer.

Reset
REQ-023 On preset13=1 the block SHALL enter IDLE with wcnt=0, pready13=0, prdata13=0, CTRL=0, WAIT=RST_WAIT13, SCRATCH=0, EVT_CNT=0, ACC_CNT=0, OVF=0, irq13=0.
REQ-024 Reset asserted mid-transfer SHALL abort it with no commit and no ACC_CNT increment.

Configuration
REQ-025 With APB_MAC_SLAVE_IRQ_EN defined: output irq13 (1 bit) = OVF & CTRL[1], and CTRL[1] IRQ_EN is rw. Without it: no irq13 port, and CTRL[1] reads 0 and ignores writes.

Structure
REQ-026 Package apb_mac_slave_pkg13 SHALL hold the register offset constants, the FSM state enum, and the WAIT field width.
REQ-027 The saturating event counter with OVF generation SHALL be sub-module apb_evt_cnt13; the FSM and decode stay in the top.

Verification
REQ-028 Reset, WAIT=0, write 0xA5A5_5A5A to 0x08, then read 0x08 -> each transfer takes 2 cycles; read returns 0xA5A5_5A5A; ACC_CNT=2.
REQ-029 Write WAIT=5, then read 0x00 -> pready13 rises in the 6th ACCESS cycle (7 cycles total); prdata13=0 before pready13.
REQ-030 EN=1, CNT_W13=8, 256 evt13 pulses -> EVT_CNT=0xFF, OVF=1; W1C STATUS with evt13 in the same cycle -> OVF remains 1.
REQ-031 Write to 0x0C coincident with evt13 -> EVT_CNT reads 0.
REQ-032 Assert preset13 during a WAIT=3 write to SCRATCH -> SCRATCH=0, ACC_CNT=0, pready13 never asserted.
REQ-033 Read 0x40 -> returns 0 after normal wait states; with APB_MAC_SLAVE_IRQ_EN defined, CTRL=0x3 plus overflow -> irq13=1.

Source files
------------

// File: rtl/apb_mac_slave13_pkg.sv
// Shared constants for the APB MAC slave: register offsets, FSM states, WAIT field width.
package apb_mac_slave_pkg13;

    localparam int unsigned WAIT_W = 3;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 32;

    localparam logic [ADDR_W-1:0] OFF_CTRL    = 8'h00;
    localparam logic [ADDR_W-1:0] OFF_WAIT    = 8'h04;
    localparam logic [ADDR_W-1:0] OFF_SCRATCH = 8'h08;
    localparam logic [ADDR_W-1:0] OFF_EVT_CNT = 8'h0C;
    localparam logic [ADDR_W-1:0] OFF_ACC_CNT = 8'h10;
    localparam logic [ADDR_W-1:0] OFF_STATUS  = 8'h14;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

endpackage

// File: rtl/apb_mac_slave13_evt_cnt.sv
// Saturating MAC event counter with sticky overflow flag (W1C, set wins over clear).
module apb_evt_cnt13 #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             evt_i,
    input  logic             clr_i,
    input  logic             ovf_clr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             hit_c;
    logic             sat_c;

    assign hit_c = en_i & evt_i;
    assign sat_c = &cnt_q;

    // Counter clear beats a coincident event; an overflow set beats a coincident W1C.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (hit_c && !sat_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (hit_c && sat_c) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/apb_mac_slave13.sv
// APB register slave for the MAC block with programmable wait states and event counters.
// Optional interrupt output and CTRL[1] IRQ_EN enabled by defining APB_MAC_SLAVE_IRQ_EN.
module apb_mac_slave13
    import apb_mac_slave_pkg13::*;
#(
    parameter logic [WAIT_W-1:0] RST_WAIT13 = 3'd0,
    parameter int unsigned       CNT_W13    = 16
) (
    input  logic              pclk13,
    input  logic              preset13,
    input  logic              psel13,
    input  logic              penable13,
    input  logic              pwrite13,
    input  logic [ADDR_W-1:0] paddr13,
    input  logic [DATA_W-1:0] pwdata13,
    output logic [DATA_W-1:0] prdata13,
    output logic              pready13,
    input  logic              evt13
`ifdef APB_MAC_SLAVE_IRQ_EN
    ,
    output logic              irq13
`endif
);

    apb_state_e         state_q, state_d;
    logic [WAIT_W-1:0]  wcnt_q, wcnt_d;
    logic               en_q, en_d;
    logic               irq_en_c;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0]  scratch_q, scratch_d;
    logic [CNT_W13-1:0] acc_q, acc_d;
    logic [CNT_W13-1:0] evt_cnt;
    logic               ovf;
    logic [ADDR_W-1:0]  addr_al;
    logic               ready_c, done_c, wr_c, rd_c;
    logic [DATA_W-1:0]  rdata_c;
    logic               unused_addr;

    assign addr_al     = {paddr13[ADDR_W-1:2], 2'b00};
    assign unused_addr = ^paddr13[1:0];
    assign ready_c     = (state_q == ST_ACCESS) && (wcnt_q == '0);
    assign done_c      = ready_c & psel13 & penable13;
    assign wr_c        = done_c & pwrite13;
    assign rd_c        = done_c & ~pwrite13;

    // FSM state register
    always_ff @(posedge pclk13) begin
        if (preset13) begin
            state_q <= ST_IDLE;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // FSM next state: WAIT is sampled only at setup, so a WAIT write never stretches its own transfer
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (psel13 && !penable13) begin
                    state_d = ST_ACCESS;
                    wcnt_d  = wait_q;
                end
            end
            ST_ACCESS: begin
                if (ready_c || !psel13) begin
                    state_d = ST_IDLE;
                end else if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        pready13 = 1'b0;
        prdata13 = '0;
        if (ready_c) begin
            pready13 = 1'b1;
        end
        if (rd_c) begin
            prdata13 = rdata_c;
        end
    end

    always_comb begin
        case (addr_al)
            OFF_CTRL:    rdata_c = {30'd0, irq_en_c, en_q};
            OFF_WAIT:    rdata_c = {29'd0, wait_q};
            OFF_SCRATCH: rdata_c = scratch_q;
            OFF_EVT_CNT: rdata_c = DATA_W'(evt_cnt);
            OFF_ACC_CNT: rdata_c = DATA_W'(acc_q);
            OFF_STATUS:  rdata_c = {31'd0, ovf};
            default:     rdata_c = '0;
        endcase
    end

`ifdef APB_MAC_SLAVE_IRQ_EN
    logic irq_en_q, irq_en_d;
    assign irq_en_c = irq_en_q;
    assign irq13    = ovf & irq_en_q;
`else
    assign irq_en_c = 1'b0;
`endif

    // Register file next state; writes land only on a completed transfer
    always_comb begin
        en_d      = en_q;
        wait_d    = wait_q;
        scratch_d = scratch_q;
        acc_d     = acc_q;
`ifdef APB_MAC_SLAVE_IRQ_EN
        irq_en_d  = irq_en_q;
`endif
        if (done_c) begin
            acc_d = acc_q + CNT_W13'(1);
        end
        if (wr_c) begin
            case (addr_al)
                OFF_CTRL: begin
                    en_d = pwdata13[0];
`ifdef APB_MAC_SLAVE_IRQ_EN
                    irq_en_d = pwdata13[1];
`endif
                end
                OFF_WAIT:    wait_d    = pwdata13[WAIT_W-1:0];
                OFF_SCRATCH: scratch_d = pwdata13;
                default: ;
            endcase
        end
    end

    always_ff @(posedge pclk13) begin
        if (preset13) begin
            en_q      <= 1'b0;
            wait_q    <= RST_WAIT13;
            scratch_q <= '0;
            acc_q     <= '0;
`ifdef APB_MAC_SLAVE_IRQ_EN
            irq_en_q  <= 1'b0;
`endif
        end else begin
            en_q      <= en_d;
            wait_q    <= wait_d;
            scratch_q <= scratch_d;
            acc_q     <= acc_d;
`ifdef APB_MAC_SLAVE_IRQ_EN
            irq_en_q  <= irq_en_d;
`endif
        end
    end

    apb_evt_cnt13 #(
        .CNT_W(CNT_W13)
    ) u_evt_cnt (
        .clk_i     (pclk13),
        .rst_i     (preset13),
        .en_i      (en_q),
        .evt_i     (evt13),
        .clr_i     (wr_c && (addr_al == OFF_EVT_CNT)),
        .ovf_clr_i (wr_c && (addr_al == OFF_STATUS) && pwdata13[0]),
        .cnt_o     (evt_cnt),
        .ovf_o     (ovf)
    );

endmodule

// File: tb/tb_apb_mac_slave13.sv
// Directed self-checking bench for apb_mac_slave13 (CNT_W13=8, RST_WAIT13=0).
module tb_apb_mac_slave13;

    logic        pclk13 = 1'b0;
    logic        preset13 = 1'b1;
    logic        psel13 = 1'b0;
    logic        penable13 = 1'b0;
    logic        pwrite13 = 1'b0;
    logic [7:0]  paddr13 = 8'h00;
    logic [31:0] pwdata13 = 32'h0;
    logic [31:0] prdata13;
    logic        pready13;
    logic        evt13 = 1'b0;
`ifdef APB_MAC_SLAVE_IRQ_EN
    logic        irq13;
`endif

    int checks = 0;
    int errors = 0;
    int acc_exp = 0;
    bit early_nz;

    always #5 pclk13 = ~pclk13;

    apb_mac_slave13 #(
        .RST_WAIT13 (3'd0),
        .CNT_W13    (8)
    ) dut (
        .pclk13    (pclk13),
        .preset13  (preset13),
        .psel13    (psel13),
        .penable13 (penable13),
        .pwrite13  (pwrite13),
        .paddr13   (paddr13),
        .pwdata13  (pwdata13),
        .prdata13  (prdata13),
        .pready13  (pready13),
        .evt13     (evt13)
`ifdef APB_MAC_SLAVE_IRQ_EN
        ,
        .irq13     (irq13)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One APB transfer; evt_acc raises evt13 in the first access cycle
    task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                        input logic evt_acc, output logic [31:0] rdata, output int cycles);
        bit got;
        got = 1'b0;
        rdata = 32'h0;
        early_nz = 1'b0;
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = wr; paddr13 = addr; pwdata13 = wdata;
        cycles = 1;
        @(posedge pclk13); #1;
        penable13 = 1'b1; evt13 = evt_acc;
        cycles = 2;
        for (int i = 0; i < 32; i++) begin
            @(negedge pclk13);
            if (pready13) begin
                rdata = prdata13;
                got = 1'b1;
                break;
            end
            if (prdata13 !== 32'h0) early_nz = 1'b1;
            @(posedge pclk13); #1;
            evt13 = 1'b0;
            cycles++;
        end
        if (!got) check("xfer_timeout", 32'(got), 32'd1);
        @(posedge pclk13); #1;
        psel13 = 1'b0; penable13 = 1'b0; evt13 = 1'b0;
        if (got) acc_exp++;
    endtask

    task automatic pulses(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pclk13); #1 evt13 = 1'b1;
            @(posedge pclk13); #1 evt13 = 1'b0;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          cyc;
        int          a_snap;
        bit          rdy_seen;

        repeat (3) @(posedge pclk13);
        #1 preset13 = 1'b0;
        @(negedge pclk13);
        check("rst_pready", 32'(pready13), 32'd0);
        check("rst_prdata", prdata13, 32'h0);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, cyc);
        check("rst_wait", rd, 32'h0);
        xfer(1'b0, 8'h08, 32'h0, 1'b0, rd, cyc);
        check("rst_scratch", rd, 32'h0);

        // Basic write/read round trip with zero wait states
        preset13 = 1'b1; @(posedge pclk13); #1 preset13 = 1'b0; acc_exp = 0;
        xfer(1'b1, 8'h08, 32'hA5A5_5A5A, 1'b0, rd, cyc);
        check("scr_wr_cycles", 32'(cyc), 32'd2);
        xfer(1'b0, 8'h08, 32'h0, 1'b0, rd, cyc);
        check("scr_rd_cycles", 32'(cyc), 32'd2);
        check("scr_rd_data", rd, 32'hA5A5_5A5A);
        xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, cyc);
        check("acc_after_2", rd, 32'd2);
        xfer(1'b0, 8'h09, 32'h0, 1'b0, rd, cyc);
        check("addr_lsb_ignored", rd, 32'hA5A5_5A5A);

        // Wait states: the WAIT write itself is still 2 cycles
        xfer(1'b1, 8'h04, 32'h0000_0005, 1'b0, rd, cyc);
        check("wait_wr_cycles", 32'(cyc), 32'd2);
        xfer(1'b0, 8'h00, 32'h0, 1'b0, rd, cyc);
        check("wait5_cycles", 32'(cyc), 32'd7);
        check("wait5_data", rd, 32'h0);
        check("wait5_prdata_early", 32'(early_nz), 32'd0);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, cyc);
        check("wait_rd", rd, 32'h5);
        xfer(1'b1, 8'h04, 32'hFFFF_FFF8, 1'b0, rd, cyc);
        check("wait0_wr_cycles", 32'(cyc), 32'd7);
        xfer(1'b0, 8'h04, 32'h0, 1'b0, rd, cyc);
        check("wait0_rd", rd, 32'h0);
        check("wait0_rd_cycles", 32'(cyc), 32'd2);

        // Event counter saturation and overflow
        xfer(1'b1, 8'h00, 32'h0000_0001, 1'b0, rd, cyc);
        pulses(256);
        xfer(1'b0, 8'h0C, 32'h0, 1'b0, rd, cyc);
        check("evt_sat", rd, 32'h0000_00FF);
        xfer(1'b0, 8'h14, 32'h0, 1'b0, rd, cyc);
        check("ovf_set", rd, 32'h1);
        xfer(1'b1, 8'h14, 32'h1, 1'b1, rd, cyc);
        xfer(1'b0, 8'h14, 32'h0, 1'b0, rd, cyc);
        check("ovf_set_wins", rd, 32'h1);
`ifdef APB_MAC_SLAVE_IRQ_EN
        xfer(1'b1, 8'h00, 32'h3, 1'b0, rd, cyc);
        @(negedge pclk13);
        check("irq_on", 32'(irq13), 32'd1);
        xfer(1'b1, 8'h00, 32'h1, 1'b0, rd, cyc);
        @(negedge pclk13);
        check("irq_off", 32'(irq13), 32'd0);
`endif
        xfer(1'b1, 8'h14, 32'h0, 1'b0, rd, cyc);
        xfer(1'b0, 8'h14, 32'h0, 1'b0, rd, cyc);
        check("ovf_w0_keeps", rd, 32'h1);
        xfer(1'b1, 8'h14, 32'h1, 1'b0, rd, cyc);
        xfer(1'b0, 8'h14, 32'h0, 1'b0, rd, cyc);
        check("ovf_w1c", rd, 32'h0);

        // Clear wins over a coincident event
        xfer(1'b1, 8'h0C, 32'hDEAD_BEEF, 1'b1, rd, cyc);
        xfer(1'b0, 8'h0C, 32'h0, 1'b0, rd, cyc);
        check("evt_clr_wins", rd, 32'h0);
        pulses(3);
        xfer(1'b0, 8'h0C, 32'h0, 1'b0, rd, cyc);
        check("evt_count3", rd, 32'h3);
        xfer(1'b1, 8'h00, 32'h0000_0003, 1'b0, rd, cyc);
        xfer(1'b0, 8'h00, 32'h0, 1'b0, rd, cyc);
`ifdef APB_MAC_SLAVE_IRQ_EN
        check("ctrl_rd", rd, 32'h3);
`else
        check("ctrl_rd", rd, 32'h1);
`endif
        xfer(1'b1, 8'h00, 32'h0, 1'b0, rd, cyc);
        pulses(2);
        xfer(1'b0, 8'h0C, 32'h0, 1'b0, rd, cyc);
        check("evt_en0_hold", rd, 32'h3);

        // Unmapped space: reads 0, ignores writes, obeys wait states
        xfer(1'b1, 8'h04, 32'h2, 1'b0, rd, cyc);
        xfer(1'b1, 8'h40, 32'h1234_5678, 1'b0, rd, cyc);
        check("unmap_wr_cycles", 32'(cyc), 32'd4);
        xfer(1'b0, 8'h40, 32'h0, 1'b0, rd, cyc);
        check("unmap_rd_data", rd, 32'h0);
        check("unmap_rd_cycles", 32'(cyc), 32'd4);
        xfer(1'b0, 8'hFC, 32'h0, 1'b0, rd, cyc);
        check("unmap_fc_data", rd, 32'h0);
        a_snap = acc_exp;
        xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, cyc);
        check("acc_total", rd, 32'(a_snap));

        // Reset in the middle of a WAIT=3 SCRATCH write
        xfer(1'b1, 8'h04, 32'h3, 1'b0, rd, cyc);
        rdy_seen = 1'b0;
        @(posedge pclk13); #1;
        psel13 = 1'b1; penable13 = 1'b0; pwrite13 = 1'b1; paddr13 = 8'h08; pwdata13 = 32'h1234_5678;
        @(posedge pclk13); #1 penable13 = 1'b1;
        @(negedge pclk13); if (pready13) rdy_seen = 1'b1;
        @(posedge pclk13); #1 preset13 = 1'b1;
        @(negedge pclk13); if (pready13) rdy_seen = 1'b1;
        @(posedge pclk13); #1 preset13 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk13); if (pready13) rdy_seen = 1'b1;
        end
        psel13 = 1'b0; penable13 = 1'b0;
        check("rst_mid_no_ready", 32'(rdy_seen), 32'd0);
        acc_exp = 0;
        xfer(1'b0, 8'h08, 32'h0, 1'b0, rd, cyc);
        check("rst_mid_scratch", rd, 32'h0);
        check("rst_mid_wait_rst", 32'(cyc), 32'd2);
        xfer(1'b0, 8'h10, 32'h0, 1'b0, rd, cyc);
        check("rst_mid_acc", rd, 32'h1);
        xfer(1'b0, 8'h14, 32'h0, 1'b0, rd, cyc);
        check("rst_mid_status", rd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
